// File: rtl/eth_rx_monitor_if.sv
// Receive byte-stream tap shared by the MAC (master) and eth_rx_monitor (slave).
// One lane per channel; channel k data sits at mac_rx_data[k*8 +: 8].
interface eth_rx_monitor_if #(
  parameter int CH_COUNT = 4
);
  logic [CH_COUNT*8-1:0] mac_rx_data;
  logic [CH_COUNT-1:0]   mac_rx_valid;
  logic [CH_COUNT-1:0]   mac_rx_sof;
  logic [CH_COUNT-1:0]   mac_rx_eof;
  logic [CH_COUNT-1:0]   mac_rx_fr_good;
  logic [CH_COUNT-1:0]   mac_rx_fr_err;

  modport master (
    output mac_rx_data, mac_rx_valid, mac_rx_sof, mac_rx_eof, mac_rx_fr_good, mac_rx_fr_err
  );

  modport slave (
    input mac_rx_data, mac_rx_valid, mac_rx_sof, mac_rx_eof, mac_rx_fr_good, mac_rx_fr_err
  );
endinterface

// File: rtl/eth_rx_monitor.sv
// N-channel receive-frame monitor: per-channel framing FSM, saturating statistics and error flags.
// Define ETH_RX_MON_LEN_CHECK_EN to enable MIN_LEN/MAX_LEN runt/giant classification.
module eth_rx_monitor #(
  parameter int CH_COUNT = 4,
  parameter int CNT_W    = 32,
  parameter int MIN_LEN  = 64,
  parameter int MAX_LEN  = 1518
) (
  input  logic                 clk,
  input  logic                 rst,
  eth_rx_monitor_if.slave      rx,
  input  logic                 clr,
  input  logic [2:0]           sel,
  input  logic                 snap,
  output logic                 snap_valid,
  output logic [CNT_W-1:0]     stat_good,
  output logic [CNT_W-1:0]     stat_bad,
  output logic [CNT_W-1:0]     stat_bytes,
  output logic [CNT_W-1:0]     stat_len_err,
  output logic [CH_COUNT-1:0]  err_pulse,
  output logic [CH_COUNT-1:0]  err_sticky,
  output logic                 err_det
);

`ifdef ETH_RX_MON_LEN_CHECK_EN
  localparam logic LEN_CHK = 1'b1;
`else
  localparam logic LEN_CHK = 1'b0;
`endif

  localparam logic [15:0]      MIN_L   = 16'(MIN_LEN);
  localparam logic [15:0]      MAX_L   = 16'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } state_t;

  function automatic logic [15:0] len_inc(input logic [15:0] l);
    return (l == 16'hFFFF) ? l : l + 16'd1;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_ONE;
  endfunction

  // Sum is one bit wider so a carry out means the counter pins at all-ones.
  function automatic logic [CNT_W-1:0] byte_add(input logic [CNT_W-1:0] c, input logic [15:0] l);
    logic [CNT_W:0] sum;
    sum = {1'b0, c} + {{(CNT_W-15){1'b0}}, l};
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  function automatic logic len_range_err(input logic [15:0] l);
    return LEN_CHK & ((l < MIN_L) | (l > MAX_L));
  endfunction

  state_t              state_r     [CH_COUNT];
  state_t              state_nxt_s [CH_COUNT];
  logic [15:0]         len_r       [CH_COUNT];
  logic [15:0]         len_nxt_s   [CH_COUNT];
  logic [15:0]         ev_len_s    [CH_COUNT];
  logic [CH_COUNT-1:0] ferr_r;
  logic [CH_COUNT-1:0] ferr_nxt_s;
  logic [CH_COUNT-1:0] ev_s;
  logic [CH_COUNT-1:0] ev_bad_s;
  logic [CH_COUNT-1:0] ev_lerr_s;

  logic [CNT_W-1:0]    good_r  [CH_COUNT];
  logic [CNT_W-1:0]    bad_r   [CH_COUNT];
  logic [CNT_W-1:0]    bytes_r [CH_COUNT];
  logic [CNT_W-1:0]    lerr_r  [CH_COUNT];

  logic [CNT_W-1:0]    mux_good_s, mux_bad_s, mux_bytes_s, mux_lerr_s;
  logic [CNT_W-1:0]    stat_good_r, stat_bad_r, stat_bytes_r, stat_lerr_r;
  logic                snap_valid_r;
  logic [CH_COUNT-1:0] err_pulse_r;
  logic [CH_COUNT-1:0] err_sticky_r;
  logic                err_det_r;

  // Framing state, running length and accumulated MAC error per channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < CH_COUNT; k++) begin
        state_r[k] <= ST_IDLE;
        len_r[k]   <= 16'd0;
      end
      ferr_r <= {CH_COUNT{1'b0}};
    end else begin
      for (int k = 0; k < CH_COUNT; k++) begin
        state_r[k] <= state_nxt_s[k];
        len_r[k]   <= len_nxt_s[k];
      end
      ferr_r <= ferr_nxt_s;
    end
  end

  // Next-state logic and end-of-frame classification; an event carries the finished frame's length.
  always_comb begin
    for (int k = 0; k < CH_COUNT; k++) begin
      state_nxt_s[k] = state_r[k];
      len_nxt_s[k]   = len_r[k];
      ferr_nxt_s[k]  = ferr_r[k];
      ev_s[k]        = 1'b0;
      ev_len_s[k]    = 16'd0;
      ev_bad_s[k]    = 1'b0;
      ev_lerr_s[k]   = 1'b0;
      case (state_r[k])
        ST_IDLE: begin
          if (rx.mac_rx_valid[k] && rx.mac_rx_sof[k] && rx.mac_rx_eof[k]) begin
            ev_s[k]      = 1'b1;
            ev_len_s[k]  = 16'd1;
            ev_lerr_s[k] = len_range_err(16'd1);
            ev_bad_s[k]  = ~rx.mac_rx_fr_good[k] | rx.mac_rx_fr_err[k] | len_range_err(16'd1);
          end else if (rx.mac_rx_valid[k] && rx.mac_rx_sof[k]) begin
            state_nxt_s[k] = ST_FRAME;
            len_nxt_s[k]   = 16'd1;
            ferr_nxt_s[k]  = rx.mac_rx_fr_err[k];
          end else begin
            state_nxt_s[k] = ST_IDLE;
          end
        end
        ST_FRAME: begin
          if (rx.mac_rx_valid[k] && rx.mac_rx_eof[k]) begin
            ev_s[k]        = 1'b1;
            ev_len_s[k]    = len_inc(len_r[k]);
            ev_lerr_s[k]   = len_range_err(len_inc(len_r[k]));
            ev_bad_s[k]    = ~rx.mac_rx_fr_good[k] | ferr_r[k] | rx.mac_rx_fr_err[k]
                             | len_range_err(len_inc(len_r[k]));
            state_nxt_s[k] = ST_IDLE;
            len_nxt_s[k]   = 16'd0;
            ferr_nxt_s[k]  = 1'b0;
          end else if (rx.mac_rx_valid[k] && rx.mac_rx_sof[k]) begin
            // Abort: the truncated frame is reported and the sof byte opens a fresh frame.
            ev_s[k]       = 1'b1;
            ev_len_s[k]   = len_r[k];
            ev_bad_s[k]   = 1'b1;
            ev_lerr_s[k]  = 1'b1;
            len_nxt_s[k]  = 16'd1;
            ferr_nxt_s[k] = rx.mac_rx_fr_err[k];
          end else if (rx.mac_rx_valid[k]) begin
            len_nxt_s[k]  = len_inc(len_r[k]);
            ferr_nxt_s[k] = ferr_r[k] | rx.mac_rx_fr_err[k];
          end else begin
            ferr_nxt_s[k] = ferr_r[k] | rx.mac_rx_fr_err[k];
          end
        end
        default: begin
          state_nxt_s[k] = ST_IDLE;
          len_nxt_s[k]   = 16'd0;
          ferr_nxt_s[k]  = 1'b0;
        end
      endcase
    end
  end

  // Saturating statistics; clr takes priority over any coincident frame event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < CH_COUNT; k++) begin
        good_r[k]  <= {CNT_W{1'b0}};
        bad_r[k]   <= {CNT_W{1'b0}};
        bytes_r[k] <= {CNT_W{1'b0}};
        lerr_r[k]  <= {CNT_W{1'b0}};
      end
    end else if (clr) begin
      for (int k = 0; k < CH_COUNT; k++) begin
        good_r[k]  <= {CNT_W{1'b0}};
        bad_r[k]   <= {CNT_W{1'b0}};
        bytes_r[k] <= {CNT_W{1'b0}};
        lerr_r[k]  <= {CNT_W{1'b0}};
      end
    end else begin
      for (int k = 0; k < CH_COUNT; k++) begin
        if (ev_s[k]) begin
          bytes_r[k] <= byte_add(bytes_r[k], ev_len_s[k]);
          if (ev_bad_s[k]) begin
            bad_r[k] <= cnt_inc(bad_r[k]);
          end else begin
            good_r[k] <= cnt_inc(good_r[k]);
          end
          if (ev_lerr_s[k]) begin
            lerr_r[k] <= cnt_inc(lerr_r[k]);
          end else begin
            lerr_r[k] <= lerr_r[k];
          end
        end else begin
          bytes_r[k] <= bytes_r[k];
        end
      end
    end
  end

  // Error pulse, sticky flags and the combined error detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_pulse_r  <= {CH_COUNT{1'b0}};
      err_sticky_r <= {CH_COUNT{1'b0}};
      err_det_r    <= 1'b0;
    end else begin
      err_pulse_r  <= ev_s & ev_bad_s;
      err_sticky_r <= clr ? {CH_COUNT{1'b0}} : (err_sticky_r | err_pulse_r);
      err_det_r    <= |err_pulse_r;
    end
  end

  // Channel select for snapshot; out-of-range selects read as zero.
  always_comb begin
    mux_good_s  = {CNT_W{1'b0}};
    mux_bad_s   = {CNT_W{1'b0}};
    mux_bytes_s = {CNT_W{1'b0}};
    mux_lerr_s  = {CNT_W{1'b0}};
    for (int k = 0; k < CH_COUNT; k++) begin
      mux_good_s  = (sel == 3'(k)) ? good_r[k]  : mux_good_s;
      mux_bad_s   = (sel == 3'(k)) ? bad_r[k]   : mux_bad_s;
      mux_bytes_s = (sel == 3'(k)) ? bytes_r[k] : mux_bytes_s;
      mux_lerr_s  = (sel == 3'(k)) ? lerr_r[k]  : mux_lerr_s;
    end
  end

  // Snapshot capture samples counters before any same-cycle clr or update lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_valid_r <= 1'b0;
      stat_good_r  <= {CNT_W{1'b0}};
      stat_bad_r   <= {CNT_W{1'b0}};
      stat_bytes_r <= {CNT_W{1'b0}};
      stat_lerr_r  <= {CNT_W{1'b0}};
    end else begin
      snap_valid_r <= snap;
      if (snap) begin
        stat_good_r  <= mux_good_s;
        stat_bad_r   <= mux_bad_s;
        stat_bytes_r <= mux_bytes_s;
        stat_lerr_r  <= mux_lerr_s;
      end else begin
        stat_good_r  <= stat_good_r;
      end
    end
  end

  assign snap_valid   = snap_valid_r;
  assign stat_good    = stat_good_r;
  assign stat_bad     = stat_bad_r;
  assign stat_bytes   = stat_bytes_r;
  assign stat_len_err = stat_lerr_r;
  assign err_pulse    = err_pulse_r;
  assign err_sticky   = err_sticky_r;
  assign err_det      = err_det_r;

endmodule

// File: tb/tb_eth_rx_monitor.sv
// Self-checking bench for eth_rx_monitor: table of single-channel frames plus multi-cycle corner sequences.
module tb_eth_rx_monitor;

`ifdef ETH_RX_MON_LEN_CHECK_EN
  localparam bit LC = 1'b1;
`else
  localparam bit LC = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clr, snap, clr16, snap16;
  logic [2:0]  sel, sel16;
  logic        snap_valid, err_det, snap_valid16, err_det16;
  logic [31:0] stat_good, stat_bad, stat_bytes, stat_len_err;
  logic [15:0] s16_good, s16_bad, s16_bytes, s16_lerr;
  logic [3:0]  err_pulse, err_sticky;
  logic [0:0]  err_pulse16, err_sticky16;

  eth_rx_monitor_if #(.CH_COUNT(4)) rx ();
  eth_rx_monitor_if #(.CH_COUNT(1)) rx16 ();

  eth_rx_monitor #(.CH_COUNT(4), .CNT_W(32), .MIN_LEN(64), .MAX_LEN(1518)) dut (
    .clk(clk), .rst(rst), .rx(rx), .clr(clr), .sel(sel), .snap(snap),
    .snap_valid(snap_valid), .stat_good(stat_good), .stat_bad(stat_bad),
    .stat_bytes(stat_bytes), .stat_len_err(stat_len_err),
    .err_pulse(err_pulse), .err_sticky(err_sticky), .err_det(err_det)
  );

  eth_rx_monitor #(.CH_COUNT(1), .CNT_W(16), .MIN_LEN(64), .MAX_LEN(1518)) dut16 (
    .clk(clk), .rst(rst), .rx(rx16), .clr(clr16), .sel(sel16), .snap(snap16),
    .snap_valid(snap_valid16), .stat_good(s16_good), .stat_bad(s16_bad),
    .stat_bytes(s16_bytes), .stat_len_err(s16_lerr),
    .err_pulse(err_pulse16), .err_sticky(err_sticky16), .err_det(err_det16)
  );

  typedef struct {
    int ch;
    int len;
    bit good;
    int errpos;
    bit exp_bad;
    bit exp_lerr;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          exp_q[$];
  int unsigned mg[4], mb[4], my[4], ml[4];
  logic [3:0]  msticky;
  logic [3:0]  prev_pulse;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      mg[k] = 0; mb[k] = 0; my[k] = 0; ml[k] = 0;
    end
    msticky = 4'b0000;
  endtask

  task automatic step(input logic [3:0] v, input logic [3:0] s, input logic [3:0] e,
                      input logic [3:0] g, input logic [3:0] fe);
    rx.mac_rx_valid   = v;
    rx.mac_rx_sof     = s;
    rx.mac_rx_eof     = e;
    rx.mac_rx_fr_good = g;
    rx.mac_rx_fr_err  = fe;
    rx.mac_rx_data    = $urandom;
    @(posedge clk);
    #1;
  endtask

  // Drives one frame of len bytes on every channel in m; the model is updated as eof is driven.
  task automatic send_multi(input logic [3:0] m, input int len, input logic [3:0] gm, input int errpos,
                            input bit snap_eof, input logic [3:0] badm, input bit lerr);
    for (int i = 0; i < len; i++) begin
      bit last;
      last = (i == len - 1);
      if (last) begin
        for (int k = 0; k < 4; k++) begin
          if (m[k]) begin
            my[k] += len;
            if (badm[k]) begin
              mb[k]++;
              msticky[k] = 1'b1;
              exp_q.push_back(k);
            end else begin
              mg[k]++;
            end
            if (lerr) ml[k]++;
          end
        end
      end
      snap = snap_eof && last;
      step(m, (i == 0) ? m : 4'b0000, last ? m : 4'b0000, last ? gm : 4'b0000,
           (i == errpos) ? m : 4'b0000);
    end
    snap = 1'b0;
    step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
  endtask

  task automatic snap_check(input int ch);
    sel  = 3'(ch);
    snap = 1'b1;
    @(posedge clk);
    #1;
    snap = 1'b0;
    check($sformatf("snap_valid_ch%0d", ch), {31'd0, snap_valid}, 32'd1);
    check($sformatf("good_ch%0d", ch),  stat_good,    (ch < 4) ? mg[ch] : 32'd0);
    check($sformatf("bad_ch%0d", ch),   stat_bad,     (ch < 4) ? mb[ch] : 32'd0);
    check($sformatf("bytes_ch%0d", ch), stat_bytes,   (ch < 4) ? my[ch] : 32'd0);
    check($sformatf("lerr_ch%0d", ch),  stat_len_err, (ch < 4) ? ml[ch] : 32'd0);
    @(posedge clk);
    #1;
    check("snap_valid_drop", {31'd0, snap_valid}, 32'd0);
  endtask

  task automatic snap16_check(input string nm, input logic [15:0] g, input logic [15:0] b,
                              input logic [15:0] y, input logic [15:0] l, input bit do_clr);
    sel16  = 3'd0;
    snap16 = 1'b1;
    clr16  = do_clr;
    @(posedge clk);
    #1;
    snap16 = 1'b0;
    clr16  = 1'b0;
    check({nm, "_valid"}, {31'd0, snap_valid16}, 32'd1);
    check({nm, "_good"},  {16'd0, s16_good},  {16'd0, g});
    check({nm, "_bad"},   {16'd0, s16_bad},   {16'd0, b});
    check({nm, "_bytes"}, {16'd0, s16_bytes}, {16'd0, y});
    check({nm, "_lerr"},  {16'd0, s16_lerr},  {16'd0, l});
  endtask

  // Scoreboard: each err_pulse bit must match the next queued bad frame; err_det trails by one cycle.
  always @(negedge clk) begin
    if (rst) begin
      prev_pulse <= 4'b0000;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (err_pulse[k]) begin
          check("err_pulse_ch", k, (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF);
        end
      end
      if (prev_pulse != 4'b0000 || err_det) begin
        check("err_det", {31'd0, err_det}, {31'd0, |prev_pulse});
      end
      prev_pulse <= err_pulse;
    end
  end

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{0, 100,  1'b1, -1, 1'b0, 1'b0};
    tbl[1]  = '{2, 64,   1'b0, -1, 1'b1, 1'b0};
    tbl[2]  = '{1, 40,   1'b1, -1, LC,   LC};
    tbl[3]  = '{1, 1600, 1'b1, -1, LC,   LC};
    tbl[4]  = '{0, 63,   1'b1, -1, LC,   LC};
    tbl[5]  = '{0, 64,   1'b1, -1, 1'b0, 1'b0};
    tbl[6]  = '{3, 1518, 1'b1, -1, 1'b0, 1'b0};
    tbl[7]  = '{3, 1519, 1'b1, -1, LC,   LC};
    tbl[8]  = '{2, 80,   1'b1, 20, 1'b1, 1'b0};
    tbl[9]  = '{1, 1,    1'b1, -1, LC,   LC};
    tbl[10] = '{2, 70,   1'b1, 69, 1'b1, 1'b0};

    rst = 1'b1; clr = 1'b0; snap = 1'b0; sel = 3'd0;
    clr16 = 1'b0; snap16 = 1'b0; sel16 = 3'd0;
    rx16.mac_rx_data = 8'd0; rx16.mac_rx_valid = 1'b0; rx16.mac_rx_sof = 1'b0;
    rx16.mac_rx_eof = 1'b0; rx16.mac_rx_fr_good = 1'b0; rx16.mac_rx_fr_err = 1'b0;
    model_reset();
    step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    check("rst_good", stat_good, 32'd0);
    check("rst_sticky", {28'd0, err_sticky}, 32'd0);
    check("rst_det", {31'd0, err_det}, 32'd0);
    check("rst_snap_valid", {31'd0, snap_valid}, 32'd0);
    rst = 1'b0;
    step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    for (int i = 0; i < 11; i++) begin
      logic [3:0] m;
      m = 4'b0001 << tbl[i].ch;
      send_multi(m, tbl[i].len, tbl[i].good ? m : 4'b0000, tbl[i].errpos, 1'b0,
                 tbl[i].exp_bad ? m : 4'b0000, tbl[i].exp_lerr);
      snap_check(tbl[i].ch);
      check($sformatf("sticky_v%0d", i), {28'd0, err_sticky}, {28'd0, msticky});
    end
    snap_check(5);

    // clr zeroes counters and sticky flags.
    clr = 1'b1;
    step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    clr = 1'b0;
    model_reset();
    step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    check("clr_sticky", {28'd0, err_sticky}, 32'd0);
    snap_check(1);

    // Abort on ch3: 10 bytes, then a new sof starts a 70-byte good frame.
    for (int i = 0; i < 10; i++) begin
      if (i == 9) begin
        my[3] += 10; mb[3]++; ml[3]++; msticky[3] = 1'b1;
        exp_q.push_back(3);
      end
      step(4'b1000, (i == 0) ? 4'b1000 : 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    end
    send_multi(4'b1000, 70, 4'b1000, -1, 1'b0, 4'b0000, 1'b0);
    snap_check(3);

    // Simultaneous eof on all channels, ch0 and ch2 with bad CRC.
    send_multi(4'b1111, 64, 4'b1010, -1, 1'b0, 4'b0101, 1'b0);
    for (int k = 0; k < 4; k++) snap_check(k);

    // Snap on the eof cycle captures pre-update counters.
    begin
      int unsigned g0, y0;
      g0 = mg[0];
      y0 = my[0];
      sel = 3'd0;
      send_multi(4'b0001, 64, 4'b0001, -1, 1'b1, 4'b0000, 1'b0);
      check("snap_pre_good", stat_good, g0);
      check("snap_pre_bytes", stat_bytes, y0);
      snap_check(0);
    end

    // Reset in the middle of a ch1 frame drops that frame.
    for (int i = 0; i < 30; i++) begin
      step(4'b0010, (i == 0) ? 4'b0010 : 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    end
    rst = 1'b1;
    model_reset();
    exp_q.delete();
    step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    check("midrst_stat_bytes", stat_bytes, 32'd0);
    check("midrst_sticky", {28'd0, err_sticky}, 32'd0);
    rst = 1'b0;
    send_multi(4'b0010, 64, 4'b0010, -1, 1'b0, 4'b0000, 1'b0);
    snap_check(1);

    // 16-bit counters: back-to-back single-byte frames drive counters to saturation.
    rx16.mac_rx_valid = 1'b1; rx16.mac_rx_sof = 1'b1; rx16.mac_rx_eof = 1'b1; rx16.mac_rx_fr_good = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    rx16.mac_rx_valid = 1'b0;
    snap16_check("sat_m1", LC ? 16'd0 : 16'hFFFE, LC ? 16'hFFFE : 16'd0, 16'hFFFE,
                 LC ? 16'hFFFE : 16'd0, 1'b0);
    rx16.mac_rx_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rx16.mac_rx_valid = 1'b0;
    snap16_check("sat", LC ? 16'd0 : 16'hFFFF, LC ? 16'hFFFF : 16'd0, 16'hFFFF,
                 LC ? 16'hFFFF : 16'd0, 1'b0);
    snap16_check("sat_clr", LC ? 16'd0 : 16'hFFFF, LC ? 16'hFFFF : 16'd0, 16'hFFFF,
                 LC ? 16'hFFFF : 16'd0, 1'b1);
    snap16_check("post_clr", 16'd0, 16'd0, 16'd0, 16'd0, 1'b0);

    step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
